// File: rtl/univ_shift_sched.sv
// Sequencer that drives a DW-bit universal shift register to serialize (TX) or
// deserialize (RX) one word per command, plus the shift register it controls.

module univ_shift_reg #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          sync_rst,
   input  logic [1:0]    ctrl,
   input  logic [DW-1:0] data,
   input  logic          data_l,
   input  logic          data_h,
   output logic [DW-1:0] q
);

   // ctrl: 00 parallel load, 10 shift left (data_l enters LSB),
   // 01 shift right (data_h enters MSB), 11 hold
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         q <= '0;
      end else begin
         unique case (ctrl)
            2'b00:   q <= data;
            2'b10:   q <= {q[DW-2:0], data_l};
            2'b01:   q <= {data_h, q[DW-1:1]};
            default: q <= q;
         endcase
      end
   end

endmodule

module univ_shift_sched #(
   parameter int DW = 4
) (
   input  logic          clk,
   input  logic          sync_rst,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic          cmd_rx,
   input  logic          cmd_dir,
   input  logic [DW-1:0] cmd_data,
   input  logic          ser_in,
   output logic          ser_out,
   output logic          ser_en,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_data,
   output logic          busy,
   output logic [1:0]    sr_ctrl,
   output logic [DW-1:0] sr_data,
   output logic          sr_data_l,
   output logic          sr_data_h,
   input  logic [DW-1:0] sr_q
);

   localparam int CW = (DW > 2) ? $clog2(DW) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(DW - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      RSP
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic [CW-1:0]   cnt_nxt;
   logic            rx_q;
   logic            dir_q;
   logic [DW-1:0]   word_q;
   logic            accept;

   assign accept   = (state == IDLE) && cmd_valid && !sync_rst;
   assign busy     = (state != IDLE);
   assign rsp_data = sr_q;

   // Command fields are captured only on the accepting IDLE cycle, so cmd_*
   // may change freely while an operation is in flight.
   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state  <= IDLE;
         cnt    <= '0;
         rx_q   <= 1'b0;
         dir_q  <= 1'b0;
         word_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            rx_q   <= cmd_rx;
            dir_q  <= cmd_dir;
            word_q <= cmd_data;
         end
      end
   end

   // Reset forces every handshake low and holds the register, even though the
   // state register only updates at the edge.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      cmd_ready = 1'b0;
      ser_en    = 1'b0;
      ser_out   = 1'b0;
      rsp_valid = 1'b0;
      sr_ctrl   = 2'b11;
      sr_data   = '0;
      sr_data_l = 1'b0;
      sr_data_h = 1'b0;
      if (!sync_rst) begin
         unique case (state)
            IDLE: begin
               cmd_ready = 1'b1;
               if (cmd_valid) begin
                  state_nxt = LOAD;
               end
            end
            LOAD: begin
               sr_ctrl   = 2'b00;
               sr_data   = rx_q ? '0 : word_q;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
            SHIFT: begin
               ser_en  = 1'b1;
               sr_ctrl = dir_q ? 2'b01 : 2'b10;
               // TX reads the bit about to leave; RX feeds the bit that enters
               if (!rx_q) begin
                  ser_out = dir_q ? sr_q[0] : sr_q[DW-1];
               end else if (dir_q) begin
                  sr_data_h = ser_in;
               end else begin
                  sr_data_l = ser_in;
               end
               cnt_nxt = cnt + CW'(1);
               if (cnt == LAST_BIT) begin
                  cnt_nxt   = '0;
                  state_nxt = rx_q ? RSP : IDLE;
               end
            end
            RSP: begin
               rsp_valid = 1'b1;
               if (rsp_ready) begin
                  state_nxt = IDLE;
               end
            end
            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule
